wb_arbiter: RTL and testbench

//  Writeback arbiter: merges ALU results and late load responses onto the register

---
 rtl/wb_arbiter_if.sv | 36 +++
 rtl/wb_arbiter.sv | 115 +++++++++++
 tb/tb_wb_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, load response, pending-load query and
// register file write port, grouped with arbiter-side (slave) and driver-side (master) views.
interface wb_arbiter_if #(
  parameter int unsigned addr_width_p = 6,
  parameter int unsigned data_width_p = 32
);
  logic                    alu_valid_i;
  logic [addr_width_p-1:0] alu_addr_i;
  logic [data_width_p-1:0] alu_data_i;
  logic                    mem_valid_i;
  logic [addr_width_p-1:0] mem_addr_i;
  logic [data_width_p-1:0] mem_data_i;
  logic                    mem_ready_o;
  logic [addr_width_p-1:0] query_addr_i;
  logic                    query_pend_o;
  logic                    wen_o;
  logic [addr_width_p-1:0] write_addr_o;
  logic [data_width_p-1:0] write_data_o;
  logic                    overflow_o;

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  mem_valid_i, mem_addr_i, mem_data_i,
    input  query_addr_i,
    output mem_ready_o, query_pend_o,
    output wen_o, write_addr_o, write_data_o, overflow_o
  );

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output mem_valid_i, mem_addr_i, mem_data_i,
    output query_addr_i,
    input  mem_ready_o, query_pend_o,
    input  wen_o, write_addr_o, write_data_o, overflow_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the register file write port; losing load
// responses queue in a small FIFO and retire in arrival order.
module wb_arbiter #(
  parameter int unsigned addr_width_p = 6,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned fifo_depth_p = 4
) (
  input  logic         clk,
  input  logic         n_reset_i,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned PW = $clog2(fifo_depth_p);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(fifo_depth_p);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [addr_width_p-1:0] addr_mem_q [fifo_depth_p];
  logic [data_width_p-1:0] data_mem_q [fifo_depth_p];
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]             count_q, count_d;

  logic                    wen_q, wen_d;
  logic [addr_width_p-1:0] write_addr_q, write_addr_d;
  logic [data_width_p-1:0] write_data_q, write_data_d;
  logic                    overflow_q, overflow_d;

  logic full, empty, push, pop, bypass;
  logic pend;
  logic [PW-1:0] off;

  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    pop          = 1'b0;
    bypass       = 1'b0;
    wen_d        = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    if (bus.alu_valid_i) begin
      wen_d        = 1'b1;
      write_addr_d = bus.alu_addr_i;
      write_data_d = bus.alu_data_i;
    end else if (!empty) begin
      pop          = 1'b1;
      wen_d        = 1'b1;
      write_addr_d = addr_mem_q[rd_ptr_q];
      write_data_d = data_mem_q[rd_ptr_q];
    end else if (bus.mem_valid_i) begin
      bypass       = 1'b1;
      wen_d        = 1'b1;
      write_addr_d = bus.mem_addr_i;
      write_data_d = bus.mem_data_i;
    end

    // Readiness uses the pre-pop count: a full FIFO never takes a push even while popping.
    push       = bus.mem_valid_i && !full && !bypass;
    overflow_d = overflow_q || (bus.mem_valid_i && full);

    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    pend = 1'b0;
    off  = '0;
    for (int unsigned i = 0; i < fifo_depth_p; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (addr_mem_q[PW'(i)] == bus.query_addr_i)) begin
        pend = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset_i) begin
    if (!n_reset_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wen_q        <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      wen_q        <= wen_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.mem_addr_i;
      data_mem_q[wr_ptr_q] <= bus.mem_data_i;
    end
  end

  assign bus.mem_ready_o  = !full;
  assign bus.query_pend_o = pend;
  assign bus.wen_o        = wen_q;
  assign bus.write_addr_o = write_addr_q;
  assign bus.write_data_o = write_data_q;
  assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: scenario tasks drive cycles into a reference
// queue model; a negedge monitor retires expected register file writes in order.
module tb_wb_arbiter;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned   c;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ld_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.addr_width_p(AW), .data_width_p(DW)) bus ();

  wb_arbiter #(
    .addr_width_p(AW),
    .data_width_p(DW),
    .fifo_depth_p(DEPTH)
  ) dut (
    .clk      (clk),
    .n_reset_i(n_reset),
    .bus      (bus)
  );

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  exp_t exp_q[$];
  ld_t  mfifo[$];
  logic model_ovf = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (n_reset === 1'b1 && bus.wen_o === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got write addr=%0d data=%h, expected no write",
                 bus.write_addr_o, bus.write_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.write_addr_o !== mon_e.a || bus.write_data_o !== mon_e.d || edge_cnt != mon_e.c) begin
          n_fail++;
          $display("FAIL wb_write: got addr=%0d data=%h cycle=%0d, expected addr=%0d data=%h cycle=%0d",
                   bus.write_addr_o, bus.write_data_o, edge_cnt, mon_e.a, mon_e.d, mon_e.c);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (n_reset === 1'b1 && bus.alu_valid_i === 1'b1 && bus.query_addr_i == bus.alu_addr_i)
      assert (bus.query_pend_o !== 1'b1)
        else $error("WAW hazard: ALU write to register %0d with a queued load pending", bus.alu_addr_i);
  end

  // Drives one clock of stimulus and advances the reference model for the same edge.
  task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    exp_t e;
    ld_t  l;
    logic rdy;
    logic byp;
    rdy = (mfifo.size() < DEPTH);
    byp = 1'b0;
    e.c = edge_cnt + 1;
    if (av) begin
      e.a = aa; e.d = ad; exp_q.push_back(e);
    end else if (mfifo.size() > 0) begin
      l = mfifo.pop_front(); e.a = l.a; e.d = l.d; exp_q.push_back(e);
    end else if (mv) begin
      e.a = ma; e.d = md; exp_q.push_back(e); byp = 1'b1;
    end
    if (mv && rdy && !byp) begin
      l.a = ma; l.d = md; mfifo.push_back(l);
    end
    if (mv && !rdy) model_ovf = 1'b1;
    bus.alu_valid_i = av; bus.alu_addr_i = aa; bus.alu_data_i = ad;
    bus.mem_valid_i = mv; bus.mem_addr_i = ma; bus.mem_data_i = md;
    @(posedge clk);
    #1;
    bus.alu_valid_i = 1'b0;
    bus.mem_valid_i = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    bus.alu_valid_i = 1'b0; bus.alu_addr_i = '0; bus.alu_data_i = '0;
    bus.mem_valid_i = 1'b0; bus.mem_addr_i = '0; bus.mem_data_i = '0;
    bus.query_addr_i = '0;
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    #1;
    n_cmp++; if (bus.wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b, expected 0", bus.wen_o); end
    n_cmp++; if (bus.write_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d, expected 0", bus.write_addr_o); end
    n_cmp++; if (bus.write_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", bus.write_data_o); end
    n_cmp++; if (bus.mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", bus.mem_ready_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", bus.overflow_o); end
    n_cmp++; if (bus.query_pend_o !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b, expected 0", bus.query_pend_o); end
    bus.query_addr_i = 6'd63;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_only();
    cycle(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    n_cmp++; if (bus.wen_o !== 1'b1 || bus.write_addr_o !== 6'd5 || bus.write_data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL alu_write: got wen=%b addr=%0d data=%h, expected 1/5/deadbeef",
                         bus.wen_o, bus.write_addr_o, bus.write_data_o);
    end
    idle(1);
    n_cmp++; if (bus.wen_o !== 1'b0 || bus.write_addr_o !== 6'd5 || bus.write_data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL alu_hold: got wen=%b addr=%0d data=%h, expected 0/5/deadbeef",
                         bus.wen_o, bus.write_addr_o, bus.write_data_o);
    end
  endtask

  task automatic test_bypass();
    bus.query_addr_i = 6'd3;
    #1;
    n_cmp++; if (bus.query_pend_o !== 1'b0) begin n_fail++; $display("FAIL bypass_pend_pre: got %b, expected 0", bus.query_pend_o); end
    cycle(1'b0, '0, '0, 1'b1, 6'd3, 32'h11);
    n_cmp++; if (bus.wen_o !== 1'b1 || bus.write_addr_o !== 6'd3 || bus.write_data_o !== 32'h11) begin
      n_fail++; $display("FAIL bypass_write: got wen=%b addr=%0d data=%h, expected 1/3/11",
                         bus.wen_o, bus.write_addr_o, bus.write_data_o);
    end
    n_cmp++; if (bus.query_pend_o !== 1'b0) begin n_fail++; $display("FAIL bypass_pend_post: got %b, expected 0", bus.query_pend_o); end
    idle(1);
    bus.query_addr_i = 6'd63;
  endtask

  task automatic test_contention();
    bus.query_addr_i = 6'd9;
    cycle(1'b1, 6'd7, 32'hA, 1'b1, 6'd9, 32'hB);
    n_cmp++; if (bus.write_addr_o !== 6'd7 || bus.write_data_o !== 32'hA) begin
      n_fail++; $display("FAIL cont_alu: got addr=%0d data=%h, expected 7/a", bus.write_addr_o, bus.write_data_o);
    end
    n_cmp++; if (bus.query_pend_o !== 1'b1) begin n_fail++; $display("FAIL cont_pend_q: got %b, expected 1", bus.query_pend_o); end
    idle(1);
    n_cmp++; if (bus.wen_o !== 1'b1 || bus.write_addr_o !== 6'd9 || bus.write_data_o !== 32'hB) begin
      n_fail++; $display("FAIL cont_load: got wen=%b addr=%0d data=%h, expected 1/9/b",
                         bus.wen_o, bus.write_addr_o, bus.write_data_o);
    end
    n_cmp++; if (bus.query_pend_o !== 1'b0) begin n_fail++; $display("FAIL cont_pend_d: got %b, expected 0", bus.query_pend_o); end
    idle(1);
    bus.query_addr_i = 6'd63;
  endtask

  task automatic test_overflow();
    for (int unsigned i = 0; i < 5; i++) begin
      n_cmp++; if (bus.mem_ready_o !== (i < DEPTH)) begin
        n_fail++; $display("FAIL ovf_ready[%0d]: got %b, expected %b", i, bus.mem_ready_o, (i < DEPTH));
      end
      cycle(1'b1, AW'(20 + i), DW'(32'hA000 + i), 1'b1, AW'(40 + i), DW'(32'hB000 + i));
    end
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, expected 1", bus.overflow_o); end
    idle(5);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain: got %0d writes outstanding, expected 0", exp_q.size()); end
    n_cmp++; if (bus.mem_ready_o !== 1'b1 || bus.overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after: got ready=%b ovf=%b, expected 1/1", bus.mem_ready_o, bus.overflow_o);
    end
  endtask

  task automatic test_mid_reset();
    bus.query_addr_i = 6'd15;
    cycle(1'b1, 6'd12, 32'hC12, 1'b1, 6'd13, 32'hC13);
    cycle(1'b1, 6'd14, 32'hC14, 1'b1, 6'd15, 32'hC15);
    n_cmp++; if (bus.query_pend_o !== 1'b1) begin n_fail++; $display("FAIL mid_pend_pre: got %b, expected 1", bus.query_pend_o); end
    #3 n_reset = 1'b0;
    #1;
    n_cmp++; if (bus.wen_o !== 1'b0 || bus.mem_ready_o !== 1'b1 || bus.overflow_o !== 1'b0 || bus.query_pend_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got wen=%b ready=%b ovf=%b pend=%b, expected 0/1/0/0",
                         bus.wen_o, bus.mem_ready_o, bus.overflow_o, bus.query_pend_o);
    end
    exp_q.delete();
    mfifo.delete();
    model_ovf = 1'b0;
    @(posedge clk);
    #1 n_reset = 1'b1;
    idle(4);
    n_cmp++; if (bus.query_pend_o !== 1'b0) begin n_fail++; $display("FAIL mid_pend_post: got %b, expected 0", bus.query_pend_o); end
    bus.query_addr_i = 6'd63;
  endtask

  task automatic test_wrap();
    bus.query_addr_i = 6'd39;
    for (int unsigned i = 0; i < 10; i++) begin
      n_cmp++; if (bus.mem_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL wrap_ready[%0d]: got %b, expected 1", i, bus.mem_ready_o);
      end
      cycle((i % 3) == 0, AW'(50 + i), DW'(32'hE000 + i), 1'b1, AW'(30 + i), DW'(32'h1000 + i));
    end
    n_cmp++; if (bus.query_pend_o !== 1'b1) begin n_fail++; $display("FAIL wrap_pend: got %b, expected 1", bus.query_pend_o); end
    idle(6);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d writes outstanding, expected 0", exp_q.size()); end
    n_cmp++; if (bus.overflow_o !== model_ovf || bus.query_pend_o !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end: got ovf=%b pend=%b, expected %b/0", bus.overflow_o, bus.query_pend_o, model_ovf);
    end
    bus.query_addr_i = 6'd63;
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_bypass();
    test_contention();
    test_overflow();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
